hilo_muldiv: RTL

//  Execute-stage HI/LO unit: the consumer of the ALU decoder's alucontrol code and HI/LO control.

---
 rtl/hilo_muldiv.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/hilo_muldiv.sv
// hilo_muldiv -- execute-stage HI/LO unit.
// Owns the architectural HI/LO registers. It performs:
//   - MULT/MULTU in a single cycle;
//   - DIV/DIVU with an iterative restoring divider, one quotient bit per cycle;
//   - MTHI/MTLO writes;
//   - MFHI/MFLO read data.
// It stalls the pipeline while a divide is in flight.
//
// State table:
//   state  | meaning
//   IDLE   | accepting new ops; MT/MULT complete here, DIV/DIVU start here
//   BUSY   | divider iterating, one quotient bit per cycle, pipeline stalled
//   DONE   | divide result ready; HI/LO written at the closing edge unless
//          | flushed or the divisor was zero
//
// Ports:
//   clk, resetn      clock (rising edge) and asynchronous active-low reset
//   valid_i, flush_i E-stage valid and flush
//   alucontrol_i     operation code
//   srca_i, srcb_i   rs / rt operands
//   hi_o, lo_o       HI / LO registers
//   hilo_rdata_o     HI for MFHI, otherwise LO (combinational)
//   stall_o          pipeline hold (combinational)
module hilo_muldiv #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          valid_i,
  input  logic          flush_i,
  input  logic [4:0]    alucontrol_i,
  input  logic [DW-1:0] srca_i,
  input  logic [DW-1:0] srcb_i,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o,
  output logic [DW-1:0] hilo_rdata_o,
  output logic          stall_o
);

  localparam logic [4:0] ALUCONTROL_MULT  = 5'd10;
  localparam logic [4:0] ALUCONTROL_MULTU = 5'd11;
  localparam logic [4:0] ALUCONTROL_DIV   = 5'd12;
  localparam logic [4:0] ALUCONTROL_DIVU  = 5'd13;
  localparam logic [4:0] ALUCONTROL_MTHI  = 5'd14;
  localparam logic [4:0] ALUCONTROL_MTLO  = 5'd15;
  localparam logic [4:0] ALUCONTROL_MFHI  = 5'd16;

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] quo_q, quo_d;   // dividend bits shift out, quotient bits shift in
  logic [DW-1:0] dvs_q, dvs_d;
  logic [DW-1:0] rem_q, rem_d;
  logic          negq_q, negq_d, negr_q, negr_d, nowr_q, nowr_d;

  logic          accept, a_neg, b_neg, step_ok;
  logic [DW-1:0] abs_a, abs_b, q_fix, r_fix;
  logic [DW:0]   rem_sh, trial;
  logic [2*DW-1:0] prod_s, prod_u;

  always_comb begin
    accept  = valid_i & ~flush_i & (state_q == S_IDLE);
    a_neg   = (alucontrol_i == ALUCONTROL_DIV) & srca_i[DW-1];
    b_neg   = (alucontrol_i == ALUCONTROL_DIV) & srcb_i[DW-1];
    abs_a   = a_neg ? (~srca_i + 1'b1) : srca_i;
    abs_b   = b_neg ? (~srcb_i + 1'b1) : srcb_i;
    rem_sh  = {rem_q, quo_q[DW-1]};
    trial   = rem_sh - {1'b0, dvs_q};
    step_ok = ~trial[DW];
    q_fix   = negq_q ? (~quo_q + 1'b1) : quo_q;
    r_fix   = negr_q ? (~rem_q + 1'b1) : rem_q;
    // Operands extended to 2*DW so the truncated product is the full product.
    prod_s  = {{DW{srca_i[DW-1]}}, srca_i} * {{DW{srcb_i[DW-1]}}, srcb_i};
    prod_u  = {{DW{1'b0}}, srca_i} * {{DW{1'b0}}, srcb_i};
  end

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    nowr_d  = nowr_q;
    stall_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (alucontrol_i)
            ALUCONTROL_MTHI:  hi_d = srca_i;
            ALUCONTROL_MTLO:  lo_d = srca_i;
            ALUCONTROL_MULT:  {hi_d, lo_d} = prod_s;
            ALUCONTROL_MULTU: {hi_d, lo_d} = prod_u;
            ALUCONTROL_DIV, ALUCONTROL_DIVU: begin
              stall_o = 1'b1;
              negq_d  = a_neg ^ b_neg;
              negr_d  = a_neg;
              quo_d   = abs_a;
              dvs_d   = abs_b;
              rem_d   = '0;
              cnt_d   = '0;
              if (srcb_i == '0) begin
                // Divide by zero: pass through DONE without touching HI/LO.
                nowr_d  = 1'b1;
                state_d = S_DONE;
              end else begin
                nowr_d  = 1'b0;
                state_d = S_BUSY;
              end
            end
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          stall_o = 1'b1;
          rem_d   = step_ok ? trial[DW-1:0] : rem_sh[DW-1:0];
          quo_d   = {quo_q[DW-2:0], step_ok};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CW'(DW - 1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (!flush_i && !nowr_q) begin
          lo_d = q_fix;
          hi_d = r_fix;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      nowr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      nowr_q  <= nowr_d;
    end
  end

  assign hi_o         = hi_q;
  assign lo_o         = lo_q;
  assign hilo_rdata_o = (alucontrol_i == ALUCONTROL_MFHI) ? hi_q : lo_q;

endmodule
